// File: rtl/seq_alu_pkg.sv
// Shared codes and types for the sequential ALU and its multiply/divide engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_alu_pkg;

    // InstructionType encodings
    localparam logic [1:0] IT_ADD = 2'b00;
    localparam logic [1:0] IT_SUB = 2'b01;
    localparam logic [1:0] IT_FN  = 2'b10;
    localparam logic [1:0] IT_ILL = 2'b11;

    // Function encodings, only meaningful when InstructionType == IT_FN
    localparam logic [4:0] FN_AND  = 5'b00000;
    localparam logic [4:0] FN_OR   = 5'b00001;
    localparam logic [4:0] FN_ADD  = 5'b00010;
    localparam logic [4:0] FN_SUB  = 5'b00011;
    localparam logic [4:0] FN_SLT  = 5'b00100;
    localparam logic [4:0] FN_SLL  = 5'b00101;
    localparam logic [4:0] FN_SRL  = 5'b00110;
    localparam logic [4:0] FN_SRA  = 5'b00111;
    localparam logic [4:0] FN_MULU = 5'b01000;
    localparam logic [4:0] FN_MUL  = 5'b01001;
    localparam logic [4:0] FN_DIVU = 5'b01010;
    localparam logic [4:0] FN_DIV  = 5'b01011;

    // Control FSM: IDLE accepts work, ITER runs the engine, FIX post-processes
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        FIX  = 2'b10
    } state_t;

    // True for the four iterative opcodes
    function automatic logic is_muldiv_fn(input logic [4:0] fn);
        return (fn == FN_MULU) || (fn == FN_MUL) || (fn == FN_DIVU) || (fn == FN_DIV);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one step per iterate.
// Latency: WIDTH iterate cycles after load; done_iter flags the final step.
// Backpressure: none; steps only when iterate=1, otherwise holds its state.
//
// Ports: load/is_div/a_mag/b_mag start an operation on magnitudes; iterate advances one step;
// lo = product low / quotient, hi = product high / remainder; done_iter = current step is the last.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             is_div,
    input  logic             iterate,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             done_iter
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic             mode_div;
    logic [WIDTH-1:0] opb;   // multiplicand or divisor, constant through the operation
    logic [WIDTH-1:0] acc;   // running product high word or partial remainder
    logic [WIDTH-1:0] sreg;  // multiplier bits shifting out / dividend bits becoming quotient

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] rem_diff;

    always_comb begin
        add_sum   = {1'b0, acc} + {1'b0, opb};
        rem_shift = {acc, sreg[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opb};
    end

    // Asserted while the step that completes the operation is being taken,
    // so the controller can leave ITER on the same edge.
    assign done_iter = (cnt == CW'(WIDTH - 1));
    assign lo        = sreg;
    assign hi        = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            mode_div <= 1'b0;
            opb      <= '0;
            acc      <= '0;
            sreg     <= '0;
        end else if (load) begin
            cnt      <= '0;
            mode_div <= is_div;
            acc      <= '0;
            if (is_div) begin
                sreg <= a_mag;
                opb  <= b_mag;
            end else begin
                sreg <= b_mag;
                opb  <= a_mag;
            end
        end else if (iterate) begin
            cnt <= cnt + CW'(1);
            if (mode_div) begin
                // rem_diff[WIDTH] set means the trial subtraction went negative: restore
                if (!rem_diff[WIDTH]) begin
                    acc  <= rem_diff[WIDTH-1:0];
                    sreg <= {sreg[WIDTH-2:0], 1'b1};
                end else begin
                    acc  <= rem_shift[WIDTH-1:0];
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                end
            end else begin
                // The carry out of the add lands in the top of acc after the shift
                if (sreg[0]) begin
                    {acc, sreg} <= {add_sum, sreg[WIDTH-1:1]};
                end else begin
                    {acc, sreg} <= {1'b0, acc, sreg[WIDTH-1:1]};
                end
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multicycle ALU with start/busy/done handshake, registered results and iterative MUL/DIV.
// Latency: 1 cycle for simple ops; WIDTH+1 cycles for MUL/MULU/DIV/DIVU.
// Backpressure: start is ignored (not queued) while busy=1; a start in the done cycle is accepted.
//
// Ports: clk, rst_n; start, BussA, BussB, InstructionType, Function in;
// Output, OutputHi, CarryOut, zero, overflow, negative, busy, done, div_by_zero out.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] BussA,
    input  logic [WIDTH-1:0] BussB,
    input  logic [1:0]       InstructionType,
    input  logic [4:0]       Function,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] OutputHi,
    output logic             CarryOut,
    output logic             zero,
    output logic             overflow,
    output logic             negative,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state_q, state_d;
    logic   accept;
    logic   load, iterate, fix;

    // ---------------- decode ----------------
    logic is_md, md_div, md_signed;

    always_comb begin
        is_md     = (InstructionType == IT_FN) && is_muldiv_fn(Function);
        md_div    = (Function == FN_DIVU) || (Function == FN_DIV);
        md_signed = (Function == FN_MUL) || (Function == FN_DIV);
    end

    assign accept = start && !busy;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && is_md) state_d = ITER;
            ITER:    if (done_iter)      state_d = FIX;
            FIX:                         state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        load    = (state_q == IDLE) && start && is_md;
        iterate = (state_q == ITER);
        fix     = (state_q == FIX);
    end

    // ---------------- simple-op datapath ----------------
    logic [WIDTH-1:0] s_out;
    logic             s_carry, s_ovf;
    logic [WIDTH:0]   add_w, sub_w;
    logic [SHW-1:0]   shamt;

    always_comb begin
        add_w   = {1'b0, BussA} + {1'b0, BussB};
        // A + ~B + 1: the carry out is 1 exactly when no borrow occurs
        sub_w   = {1'b0, BussA} + {1'b0, ~BussB} + {{WIDTH{1'b0}}, 1'b1};
        shamt   = BussB[SHW-1:0];
        s_out   = '0;
        s_carry = 1'b0;
        s_ovf   = 1'b0;
        case (InstructionType)
            IT_ADD: begin
                s_out   = add_w[WIDTH-1:0];
                s_carry = add_w[WIDTH];
                s_ovf   = (BussA[WIDTH-1] == BussB[WIDTH-1]) && (add_w[WIDTH-1] != BussA[WIDTH-1]);
            end
            IT_SUB: begin
                s_out   = sub_w[WIDTH-1:0];
                s_carry = sub_w[WIDTH];
                s_ovf   = (BussA[WIDTH-1] != BussB[WIDTH-1]) && (sub_w[WIDTH-1] != BussA[WIDTH-1]);
            end
            IT_FN: begin
                case (Function)
                    FN_AND: s_out = BussA & BussB;
                    FN_OR:  s_out = BussA | BussB;
                    FN_ADD: begin
                        s_out   = add_w[WIDTH-1:0];
                        s_carry = add_w[WIDTH];
                        s_ovf   = (BussA[WIDTH-1] == BussB[WIDTH-1]) && (add_w[WIDTH-1] != BussA[WIDTH-1]);
                    end
                    FN_SUB: begin
                        s_out   = sub_w[WIDTH-1:0];
                        s_carry = sub_w[WIDTH];
                        s_ovf   = (BussA[WIDTH-1] != BussB[WIDTH-1]) && (sub_w[WIDTH-1] != BussA[WIDTH-1]);
                    end
                    FN_SLT: s_out = {{(WIDTH-1){1'b0}}, ($signed(BussA) < $signed(BussB))};
                    FN_SLL: s_out = BussA << shamt;
                    FN_SRL: s_out = BussA >> shamt;
                    FN_SRA: s_out = $unsigned($signed(BussA) >>> shamt);
                    default: s_out = '0;
                endcase
            end
            default: s_out = '0;
        endcase
    end

    // ---------------- MUL/DIV sign pre-processing ----------------
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             sign_a_q, sign_b_q, signed_q, div_q;
    logic [WIDTH-1:0] a_q, b_q;

    always_comb begin
        a_mag = (md_signed && BussA[WIDTH-1]) ? -BussA : BussA;
        b_mag = (md_signed && BussB[WIDTH-1]) ? -BussB : BussB;
    end

    // Raw operands are kept for the divide-by-zero and MIN/-1 special cases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            signed_q <= 1'b0;
            div_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else if (load) begin
            sign_a_q <= md_signed && BussA[WIDTH-1];
            sign_b_q <= md_signed && BussB[WIDTH-1];
            signed_q <= md_signed;
            div_q    <= md_div;
            a_q      <= BussA;
            b_q      <= BussB;
        end
    end

    // ---------------- iterative engine ----------------
    logic [WIDTH-1:0] md_lo, md_hi;
    logic             done_iter;

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .is_div    (md_div),
        .iterate   (iterate),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .lo        (md_lo),
        .hi        (md_hi),
        .done_iter (done_iter)
    );

    // ---------------- MUL/DIV sign post-processing ----------------
    logic [WIDTH-1:0]   m_out, m_hi, quo, rem;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic               m_ovf, m_dbz;

    always_comb begin
        prod_mag = {md_hi, md_lo};
        prod     = (signed_q && (sign_a_q ^ sign_b_q)) ? -prod_mag : prod_mag;
        // Truncating division: quotient sign = sign xor, remainder follows the dividend
        quo      = (signed_q && (sign_a_q ^ sign_b_q)) ? -md_lo : md_lo;
        rem      = (signed_q && sign_a_q) ? -md_hi : md_hi;
        m_out    = '0;
        m_hi     = '0;
        m_ovf    = 1'b0;
        m_dbz    = 1'b0;
        if (!div_q) begin
            m_out = prod[WIDTH-1:0];
            m_hi  = prod[2*WIDTH-1:WIDTH];
            if (signed_q) begin
                m_ovf = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
            end else begin
                m_ovf = (prod[2*WIDTH-1:WIDTH] != '0);
            end
        end else if (b_q == '0) begin
            m_out = '1;
            m_hi  = a_q;
            m_dbz = 1'b1;
        end else begin
            // MIN / -1 already yields MIN with remainder 0 after negation; only the flag is special
            m_out = quo;
            m_hi  = rem;
            m_ovf = signed_q && (a_q == MIN_VAL) && (b_q == '1);
        end
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Output      <= '0;
            OutputHi    <= '0;
            CarryOut    <= 1'b0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            negative    <= 1'b0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else if (accept && !is_md) begin
            Output      <= s_out;
            OutputHi    <= '0;
            CarryOut    <= s_carry;
            zero        <= (s_out == '0);
            overflow    <= s_ovf;
            negative    <= s_out[WIDTH-1];
            div_by_zero <= 1'b0;
            done        <= 1'b1;
        end else if (fix) begin
            Output      <= m_out;
            OutputHi    <= m_hi;
            CarryOut    <= 1'b0;
            zero        <= (m_out == '0);
            overflow    <= m_ovf;
            negative    <= m_out[WIDTH-1];
            div_by_zero <= m_dbz;
            done        <= 1'b1;
        end else begin
            done        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] BussA, BussB;
    logic [1:0]  InstructionType;
    logic [4:0]  Function;
    logic [31:0] Output, OutputHi;
    logic        CarryOut, zero, overflow, negative, busy, done, div_by_zero;

    int checks = 0;
    int failures = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .BussA           (BussA),
        .BussB           (BussB),
        .InstructionType (InstructionType),
        .Function        (Function),
        .Output          (Output),
        .OutputHi        (OutputHi),
        .CarryOut        (CarryOut),
        .zero            (zero),
        .overflow        (overflow),
        .negative        (negative),
        .busy            (busy),
        .done            (done),
        .div_by_zero     (div_by_zero)
    );

    always #5 clk = ~clk;

    // flags packed as {CarryOut, zero, overflow, negative, div_by_zero}
    typedef struct {
        logic [1:0]  it;
        logic [4:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic [31:0] hi;
        logic [4:0]  flg;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [4:0] cur_flags();
        return {CarryOut, zero, overflow, negative, div_by_zero};
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%08h expected=%08h", nm, idx, got, exp);
        end
    endtask

    // Drives one request; returns the edge index (0 = accepting edge) after which done was seen
    // and the number of sampled cycles with busy high.
    task automatic run_op(input logic [1:0] it, input logic [4:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input int idx, output int lat, output int bcnt);
        InstructionType = it;
        Function        = fn;
        BussA           = a;
        BussB           = b;
        start           = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", idx, 32'(done), 32'd1);
    endtask

    initial begin
        int lat, bcnt;

        // idx it     fn        A             B             Output        OutputHi      CZVND     lat
        vecs.push_back(vec_t'{2'b10, 5'b00010, 32'h00000003, 32'h00000001, 32'h00000004, 32'h0, 5'b00000, 0});
        vecs.push_back(vec_t'{2'b01, 5'b00000, 32'h00000001, 32'h00000003, 32'hFFFFFFFE, 32'h0, 5'b00010, 0});
        vecs.push_back(vec_t'{2'b10, 5'b00010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 5'b00110, 0});
        vecs.push_back(vec_t'{2'b00, 5'b00000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 5'b11000, 0});
        vecs.push_back(vec_t'{2'b10, 5'b00011, 32'h00000005, 32'h00000003, 32'h00000002, 32'h0, 5'b10000, 0});
        vecs.push_back(vec_t'{2'b01, 5'b00000, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 5'b10100, 0});
        vecs.push_back(vec_t'{2'b10, 5'b00000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 5'b00000, 0});
        vecs.push_back(vec_t'{2'b10, 5'b00001, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0, 5'b00010, 0});
        vecs.push_back(vec_t'{2'b10, 5'b00100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 5'b00000, 0});
        vecs.push_back(vec_t'{2'b10, 5'b00100, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0, 5'b01000, 0});
        vecs.push_back(vec_t'{2'b10, 5'b00101, 32'h00000001, 32'h00000024, 32'h00000010, 32'h0, 5'b00000, 0});
        vecs.push_back(vec_t'{2'b10, 5'b00110, 32'h80000000, 32'h0000001F, 32'h00000001, 32'h0, 5'b00000, 0});
        vecs.push_back(vec_t'{2'b10, 5'b00111, 32'h80000000, 32'h00000004, 32'hF8000000, 32'h0, 5'b00010, 0});
        vecs.push_back(vec_t'{2'b11, 5'b00010, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 5'b01000, 0});
        vecs.push_back(vec_t'{2'b10, 5'b01100, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 5'b01000, 0});
        vecs.push_back(vec_t'{2'b10, 5'b01001, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'hFFFFFFFF, 5'b00010, 33});
        vecs.push_back(vec_t'{2'b10, 5'b01000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 5'b00110, 33});
        vecs.push_back(vec_t'{2'b10, 5'b01001, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 5'b01100, 33});
        vecs.push_back(vec_t'{2'b10, 5'b01011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 5'b00010, 33});
        vecs.push_back(vec_t'{2'b10, 5'b01010, 32'h0000000A, 32'h00000000, 32'hFFFFFFFF, 32'h0000000A, 5'b00011, 33});
        vecs.push_back(vec_t'{2'b10, 5'b01011, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 5'b00110, 33});
        vecs.push_back(vec_t'{2'b10, 5'b01010, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 5'b00000, 33});
        vecs.push_back(vec_t'{2'b10, 5'b01011, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 5'b00010, 33});
        vecs.push_back(vec_t'{2'b10, 5'b01011, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 5'b00011, 33});

        // ---- reset state ----
        rst_n = 1'b0;
        start = 1'b0;
        BussA = '0;
        BussB = '0;
        InstructionType = '0;
        Function = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 0, Output, 32'h0);
        check("rst_hi", 0, OutputHi, 32'h0);
        check("rst_flags", 0, 32'(cur_flags()), 32'h0);
        check("rst_busy_done", 0, 32'({busy, done}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- table-driven vectors ----
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].it, vecs[i].fn, vecs[i].a, vecs[i].b, i, lat, bcnt);
            check("out", i, Output, vecs[i].out);
            check("hi", i, OutputHi, vecs[i].hi);
            check("flags", i, 32'(cur_flags()), 32'(vecs[i].flg));
            check("latency", i, 32'(lat), 32'(vecs[i].lat));
            check("busy_cycles", i, 32'(bcnt), 32'(vecs[i].lat));
            @(posedge clk); #1;
            check("done_pulse", i, 32'(done), 32'd0);
        end

        // ---- start while busy is ignored ----
        InstructionType = 2'b10;
        Function        = 5'b01001;
        BussA           = 32'd2;
        BussB           = 32'd3;
        start           = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        repeat (4) begin
            @(posedge clk); #1;
            lat++;
        end
        InstructionType = 2'b00;
        BussA           = 32'd9;
        BussB           = 32'd9;
        start           = 1'b1;
        @(posedge clk); #1;
        lat++;
        start = 1'b0;
        check("ign_busy", 100, 32'(busy), 32'd1);
        check("ign_no_done", 100, 32'(done), 32'd0);
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ign_latency", 100, 32'(lat), 32'd33);
        check("ign_out", 100, Output, 32'd6);
        @(posedge clk); #1;
        check("ign_no_extra_done", 100, 32'(done), 32'd0);
        check("ign_out_held", 100, Output, 32'd6);

        // ---- back-to-back: ADD accepted in the MUL done cycle ----
        run_op(2'b10, 5'b01000, 32'd5, 32'd5, 101, lat, bcnt);
        check("b2b_mul_out", 101, Output, 32'd25);
        check("b2b_busy_in_done", 101, 32'(busy), 32'd0);
        InstructionType = 2'b00;
        BussA           = 32'd3;
        BussB           = 32'd1;
        start           = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_add_done", 101, 32'(done), 32'd1);
        check("b2b_add_out", 101, Output, 32'd4);
        check("b2b_add_hi", 101, OutputHi, 32'd0);
        @(posedge clk); #1;
        check("b2b_done_drop", 101, 32'(done), 32'd0);

        // ---- reset during a DIV ----
        InstructionType = 2'b10;
        Function        = 5'b01010;
        BussA           = 32'd100;
        BussB           = 32'd7;
        start           = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out", 102, Output, 32'h0);
        check("arst_hi", 102, OutputHi, 32'h0);
        check("arst_flags", 102, 32'(cur_flags()), 32'h0);
        check("arst_busy_done", 102, 32'({busy, done}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b10, 5'b01010, 32'd100, 32'd7, 103, lat, bcnt);
        check("cold_out", 103, Output, 32'd14);
        check("cold_hi", 103, OutputHi, 32'd2);
        check("cold_latency", 103, 32'(lat), 32'd33);
        check("cold_flags", 103, 32'(cur_flags()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
